// File: rtl/bus_fabric.sv
// Registered address decoder and CPU-to-slave handshake bridge for ROM, RAM and video.
// Unmapped accesses, ROM writes and slave timeouts complete with a sticky error flag.
module bus_fabric #(
  parameter logic [31:0] ROM_BASE   = 32'h0000_0000,
  parameter logic [31:0] ROM_SIZE   = 32'h0002_0000,
  parameter logic [31:0] RAM_BASE   = 32'h0002_0000,
  parameter logic [31:0] RAM_SIZE   = 32'h0001_0000,
  parameter logic [31:0] VIDEO_BASE = 32'h1000_0000,
  parameter logic [31:0] VIDEO_SIZE = 32'h1000_0000,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_cpu_request,
  input  logic        i_cpu_rw,
  input  logic [31:0] i_cpu_address,
  input  logic [31:0] i_cpu_wdata,
  output logic        o_cpu_ready,
  output logic [31:0] o_cpu_rdata,
  output logic        o_slave_rw,
  output logic [31:0] o_slave_address,
  output logic [31:0] o_slave_wdata,
  output logic        o_rom_request,
  input  logic        i_rom_ready,
  input  logic [31:0] i_rom_rdata,
  output logic        o_ram_request,
  input  logic        i_ram_ready,
  input  logic [31:0] i_ram_rdata,
  output logic        o_video_request,
  input  logic        i_video_ready,
  input  logic [31:0] i_video_rdata,
  output logic        o_error,
  output logic [31:0] o_error_address
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  // 33-bit compare so a region ending at the top of the map does not wrap.
  function automatic logic in_region(input logic [AW-1:0] a, input logic [AW-1:0] base,
                                     input logic [AW-1:0] size);
    return ({1'b0, a} >= {1'b0, base}) && ({1'b0, a} < ({1'b0, base} + {1'b0, size}));
  endfunction

  logic [1:0]    r_state,    w_state_nxt;
  logic [CW-1:0] r_cnt,      w_cnt_nxt;
  logic          r_ready,    w_ready_nxt;
  logic [DW-1:0] r_rdata,    w_rdata_nxt;
  logic          r_rw,       w_rw_nxt;
  logic [AW-1:0] r_addr,     w_addr_nxt;
  logic [AW-1:0] r_txn_addr, w_txn_addr_nxt;
  logic [DW-1:0] r_wdata,    w_wdata_nxt;
  logic          r_rom_req,  w_rom_req_nxt;
  logic          r_ram_req,  w_ram_req_nxt;
  logic          r_vid_req,  w_vid_req_nxt;
  logic          r_error,    w_error_nxt;
  logic [AW-1:0] r_err_addr, w_err_addr_nxt;

  logic          w_hit_rom, w_hit_ram, w_hit_vid;
  logic          w_sel_ready;
  logic [DW-1:0] w_sel_rdata;
  logic [CW-1:0] w_cnt_inc;
  logic          w_fail;
  logic [AW-1:0] w_fail_addr;

  assign w_hit_rom   = in_region(i_cpu_address, ROM_BASE, ROM_SIZE);
  assign w_hit_ram   = in_region(i_cpu_address, RAM_BASE, RAM_SIZE);
  assign w_hit_vid   = in_region(i_cpu_address, VIDEO_BASE, VIDEO_SIZE);
  assign w_cnt_inc   = r_cnt + CW'(1);

  // Only the slave currently being requested may complete the access.
  assign w_sel_ready = (r_rom_req & i_rom_ready) | (r_ram_req & i_ram_ready) |
                       (r_vid_req & i_video_ready);
  assign w_sel_rdata = r_rom_req ? i_rom_rdata :
                       r_ram_req ? i_ram_rdata :
                       r_vid_req ? i_video_rdata : '0;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_ready_nxt    = r_ready;
    w_rdata_nxt    = r_rdata;
    w_rw_nxt       = r_rw;
    w_addr_nxt     = r_addr;
    w_txn_addr_nxt = r_txn_addr;
    w_wdata_nxt    = r_wdata;
    w_rom_req_nxt  = r_rom_req;
    w_ram_req_nxt  = r_ram_req;
    w_vid_req_nxt  = r_vid_req;
    w_error_nxt    = r_error;
    w_err_addr_nxt = r_err_addr;
    w_fail         = 1'b0;
    w_fail_addr    = i_cpu_address;

    case (r_state)
      S_IDLE: begin
        if (i_cpu_request) begin
          w_rw_nxt       = i_cpu_rw;
          w_wdata_nxt    = i_cpu_wdata;
          w_txn_addr_nxt = i_cpu_address;
          w_rdata_nxt    = '0;
          w_cnt_nxt      = '0;
          w_state_nxt    = S_ACCESS;
          if (w_hit_rom && !i_cpu_rw) begin
            w_rom_req_nxt = 1'b1;
            w_addr_nxt    = i_cpu_address - ROM_BASE;
          end else if (w_hit_ram) begin
            w_ram_req_nxt = 1'b1;
            w_addr_nxt    = i_cpu_address - RAM_BASE;
          end else if (w_hit_vid) begin
            w_vid_req_nxt = 1'b1;
            w_addr_nxt    = i_cpu_address - VIDEO_BASE;
          end else begin
            w_addr_nxt  = w_hit_rom ? (i_cpu_address - ROM_BASE) : i_cpu_address;
            w_ready_nxt = 1'b1;
            w_fail      = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_ACCESS: begin
        if (w_sel_ready) begin
          w_rdata_nxt   = r_rw ? '0 : w_sel_rdata;
          w_rom_req_nxt = 1'b0;
          w_ram_req_nxt = 1'b0;
          w_vid_req_nxt = 1'b0;
          w_ready_nxt   = 1'b1;
          w_state_nxt   = S_DONE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == CW'(TIMEOUT)) begin
            w_rom_req_nxt = 1'b0;
            w_ram_req_nxt = 1'b0;
            w_vid_req_nxt = 1'b0;
            w_rdata_nxt   = '0;
            w_ready_nxt   = 1'b1;
            w_fail        = 1'b1;
            w_fail_addr   = r_txn_addr;
            w_state_nxt   = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!i_cpu_request) begin
          w_ready_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_rom_req_nxt = 1'b0;
        w_ram_req_nxt = 1'b0;
        w_vid_req_nxt = 1'b0;
        w_ready_nxt   = 1'b0;
        w_state_nxt   = S_IDLE;
      end
    endcase

    // Error flag is sticky; only the first failing address is kept.
    if (w_fail) begin
      w_error_nxt = 1'b1;
      if (!r_error) w_err_addr_nxt = w_fail_addr;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_ready    <= 1'b0;
      r_rdata    <= '0;
      r_rw       <= 1'b0;
      r_addr     <= '0;
      r_txn_addr <= '0;
      r_wdata    <= '0;
      r_rom_req  <= 1'b0;
      r_ram_req  <= 1'b0;
      r_vid_req  <= 1'b0;
      r_error    <= 1'b0;
      r_err_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ready    <= w_ready_nxt;
      r_rdata    <= w_rdata_nxt;
      r_rw       <= w_rw_nxt;
      r_addr     <= w_addr_nxt;
      r_txn_addr <= w_txn_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_rom_req  <= w_rom_req_nxt;
      r_ram_req  <= w_ram_req_nxt;
      r_vid_req  <= w_vid_req_nxt;
      r_error    <= w_error_nxt;
      r_err_addr <= w_err_addr_nxt;
    end
  end

  assign o_cpu_ready     = r_ready;
  assign o_cpu_rdata     = r_rdata;
  assign o_slave_rw      = r_rw;
  assign o_slave_address = r_addr;
  assign o_slave_wdata   = r_wdata;
  assign o_rom_request   = r_rom_req;
  assign o_ram_request   = r_ram_req;
  assign o_video_request = r_vid_req;
  assign o_error         = r_error;
  assign o_error_address = r_err_addr;

endmodule

// File: tb/tb_bus_fabric.sv
// Directed bench for bus_fabric: expected completions queued at issue, compared at o_cpu_ready.
module tb_bus_fabric;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] err_addr;
  } exp_t;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_cpu_request = 1'b0;
  logic        i_cpu_rw = 1'b0;
  logic [31:0] i_cpu_address = '0;
  logic [31:0] i_cpu_wdata = '0;
  logic        o_cpu_ready;
  logic [31:0] o_cpu_rdata;
  logic        o_slave_rw;
  logic [31:0] o_slave_address;
  logic [31:0] o_slave_wdata;
  logic        o_rom_request;
  logic        i_rom_ready = 1'b0;
  logic [31:0] i_rom_rdata = '0;
  logic        o_ram_request;
  logic        i_ram_ready = 1'b0;
  logic [31:0] i_ram_rdata = '0;
  logic        o_video_request;
  logic        i_video_ready = 1'b0;
  logic [31:0] i_video_rdata = '0;
  logic        o_error;
  logic [31:0] o_error_address;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t dropped;
  int   rom_delay = 0, ram_delay = 0, vid_delay = 0;
  int   rom_k = 0, ram_k = 0, vid_k = 0;

  bus_fabric dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_cpu_request(i_cpu_request), .i_cpu_rw(i_cpu_rw),
    .i_cpu_address(i_cpu_address), .i_cpu_wdata(i_cpu_wdata),
    .o_cpu_ready(o_cpu_ready), .o_cpu_rdata(o_cpu_rdata),
    .o_slave_rw(o_slave_rw), .o_slave_address(o_slave_address),
    .o_slave_wdata(o_slave_wdata),
    .o_rom_request(o_rom_request), .i_rom_ready(i_rom_ready), .i_rom_rdata(i_rom_rdata),
    .o_ram_request(o_ram_request), .i_ram_ready(i_ram_ready), .i_ram_rdata(i_ram_rdata),
    .o_video_request(o_video_request), .i_video_ready(i_video_ready),
    .i_video_rdata(i_video_rdata),
    .o_error(o_error), .o_error_address(o_error_address)
  );

  always #5 i_clock = ~i_clock;

  // Slave responders: ready rises once the request has been seen for more than <delay> cycles.
  always @(negedge i_clock) begin
    if (o_rom_request) begin rom_k++; i_rom_ready = (rom_k > rom_delay); end
    else begin rom_k = 0; i_rom_ready = 1'b0; end
    if (o_ram_request) begin ram_k++; i_ram_ready = (ram_k > ram_delay); end
    else begin ram_k = 0; i_ram_ready = 1'b0; end
    if (o_video_request) begin vid_k++; i_video_ready = (vid_k > vid_delay); end
    else begin vid_k = 0; i_video_ready = 1'b0; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one transaction at a negedge, wait (bounded) for o_cpu_ready, then score it.
  task automatic run_txn(input string tag, input logic rw, input logic [31:0] addr,
                         input logic [31:0] wdata, input int exp_lat, input int exp_reqc,
                         input exp_t e);
    int   n;
    int   reqc;
    exp_t got;
    sb.push_back(e);
    i_cpu_request = 1'b1;
    i_cpu_rw      = rw;
    i_cpu_address = addr;
    i_cpu_wdata   = wdata;
    n = 0;
    reqc = 0;
    do begin
      @(negedge i_clock);
      n++;
      if (o_rom_request | o_ram_request | o_video_request) reqc++;
    end while (!o_cpu_ready && n < 400);
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    chk({tag, "_req_cycles"}, 32'(reqc), 32'(exp_reqc));
    got = sb.pop_front();
    chk({tag, "_rdata"}, o_cpu_rdata, got.rdata);
    chk({tag, "_error"}, 32'(o_error), 32'(got.err));
    chk({tag, "_error_addr"}, o_error_address, got.err_addr);
  endtask

  task automatic end_txn(input string tag);
    i_cpu_request = 1'b0;
    @(negedge i_clock);
    chk({tag, "_ready_low"}, 32'(o_cpu_ready), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge i_clock);
    chk("rst_ready", 32'(o_cpu_ready), 32'd0);
    chk("rst_rdata", o_cpu_rdata, 32'd0);
    chk("rst_error", 32'(o_error), 32'd0);
    chk("rst_err_addr", o_error_address, 32'd0);
    chk("rst_reqs", {29'd0, o_rom_request, o_ram_request, o_video_request}, 32'd0);
    i_reset = 1'b1;
    @(negedge i_clock);

    rom_delay = 0;
    i_rom_rdata = 32'h1234_5678;
    run_txn("rom_rd", 1'b0, 32'h0000_0200, 32'd0, 2, 1, '{32'h1234_5678, 1'b0, 32'd0});
    chk("rom_rd_slave_addr", o_slave_address, 32'h200);
    end_txn("rom_rd");

    ram_delay = 3;
    run_txn("ram_wr", 1'b1, 32'h0002_0010, 32'hCAFE_BABE, 5, 4, '{32'd0, 1'b0, 32'd0});
    i_cpu_address = 32'hDEAD_0000;
    i_cpu_wdata   = 32'h0;
    @(negedge i_clock);
    chk("ram_wr_ready_held", 32'(o_cpu_ready), 32'd1);
    chk("ram_wr_slave_addr", o_slave_address, 32'h10);
    chk("ram_wr_slave_wdata", o_slave_wdata, 32'hCAFE_BABE);
    chk("ram_wr_slave_rw", 32'(o_slave_rw), 32'd1);
    end_txn("ram_wr");

    run_txn("unmapped", 1'b0, 32'h0003_0000, 32'd0, 1, 0, '{32'd0, 1'b1, 32'h0003_0000});
    end_txn("unmapped");

    vid_delay = 1000;
    i_video_rdata = 32'h55AA_55AA;
    run_txn("vid_tmo", 1'b0, 32'h1000_0004, 32'd0, 256, 255, '{32'd0, 1'b1, 32'h0003_0000});
    chk("vid_tmo_slave_addr", o_slave_address, 32'h4);
    end_txn("vid_tmo");

    run_txn("rom_wr", 1'b1, 32'h0000_0100, 32'h1111_1111, 1, 0, '{32'd0, 1'b1, 32'h0003_0000});
    end_txn("rom_wr");

    ram_delay = 0;
    i_ram_rdata = 32'hA5A5_0001;
    run_txn("b2b_0", 1'b0, 32'h0002_0000, 32'd0, 2, 1, '{32'hA5A5_0001, 1'b1, 32'h0003_0000});
    end_txn("b2b_0");
    i_ram_rdata = 32'hA5A5_0002;
    run_txn("b2b_1", 1'b0, 32'h0002_0004, 32'd0, 2, 1, '{32'hA5A5_0002, 1'b1, 32'h0003_0000});
    chk("b2b_1_slave_addr", o_slave_address, 32'h4);
    end_txn("b2b_1");

    // Reset in the middle of a RAM read: the queued completion is abandoned.
    ram_delay = 10;
    sb.push_back('{32'd0, 1'b0, 32'd0});
    i_cpu_request = 1'b1;
    i_cpu_rw      = 1'b0;
    i_cpu_address = 32'h0002_0008;
    repeat (2) @(negedge i_clock);
    chk("rst_mid_ram_req_before", 32'(o_ram_request), 32'd1);
    #2 i_reset = 1'b0;
    #1;
    chk("rst_mid_ram_req", 32'(o_ram_request), 32'd0);
    chk("rst_mid_ready", 32'(o_cpu_ready), 32'd0);
    chk("rst_mid_error", 32'(o_error), 32'd0);
    chk("rst_mid_err_addr", o_error_address, 32'd0);
    dropped = sb.pop_front();
    i_cpu_request = 1'b0;
    @(negedge i_clock);
    i_reset = 1'b1;
    @(negedge i_clock);
    ram_delay = 0;
    i_ram_rdata = 32'h0BAD_F00D;
    run_txn("post_rst", 1'b0, 32'h0002_000C, 32'd0, 2, 1, '{32'h0BAD_F00D, 1'b0, 32'd0});
    chk("post_rst_slave_addr", o_slave_address, 32'hC);
    end_txn("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_fabric.md
Name: bus_fabric

Overview:
- Registered address decoder and handshake bridge between the CPU master port and the ROM, RAM and video slaves.
- Replaces the combinational enable/mux glue around the CPU. Forwards one transaction at a time to the selected slave and returns read data in a register.
- Completes accesses to unmapped addresses, writes to ROM, and slave timeouts with an error indication, so the CPU never hangs.

Parameters:
- ROM_BASE, 32'h00000000, ROM region base; region is [ROM_BASE, ROM_BASE+ROM_SIZE)
- ROM_SIZE, 32'h00020000, ROM region size in bytes
- RAM_BASE, 32'h00020000, RAM region base
- RAM_SIZE, 32'h00010000, RAM region size
- VIDEO_BASE, 32'h10000000, video region base
- VIDEO_SIZE, 32'h10000000, video region size
- TIMEOUT, 255, maximum cycles spent waiting for slave ready; 8-bit counter

Ports:
- i_clock  in  1  clock; all state updates on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_cpu_request  in  1  CPU request; held high until o_cpu_ready is seen
- i_cpu_rw  in  1  1 = write, 0 = read; stable while request is high
- i_cpu_address  in  32  byte address
- i_cpu_wdata  in  32  write data
- o_cpu_ready  out  1  transaction complete
- o_cpu_rdata  out  32  registered read data
- o_slave_rw  out  1  latched rw
- o_slave_address  out  32  latched address minus region base
- o_slave_wdata  out  32  latched write data
- o_rom_request  out  1  ROM select
- i_rom_ready  in  1  ROM ready
- i_rom_rdata  in  32  ROM read data
- o_ram_request  out  1  RAM select
- i_ram_ready  in  1  RAM ready
- i_ram_rdata  in  32  RAM read data
- o_video_request  out  1  video select
- i_video_ready  in  1  video ready
- i_video_rdata  in  32  video read data
- o_error  out  1  sticky error flag; cleared only by reset
- o_error_address  out  32  address of the first failing transaction

Behaviour:
- Reset (i_reset low, asynchronous): state IDLE; every output 0, including o_cpu_rdata and o_error_address. A transaction in flight is abandoned and slave requests drop immediately.
- States: IDLE, ACCESS, DONE.
- IDLE, on edge with i_cpu_request=1:
  - Latch rw, wdata and address-minus-base into o_slave_*.
  - Decode using base <= addr < base+size, compared in 33-bit arithmetic so there is no wrap at 0xFFFFFFFF.
  - Mapped, and not a ROM write: raise exactly one o_*_request; clear the timeout counter; go to ACCESS.
  - Unmapped, or ROM write: no slave request; o_cpu_ready=1, o_cpu_rdata=0; set o_error (and o_error_address if o_error was 0); go to DONE.
- ACCESS, on edge:
  - Selected slave ready=1: capture its rdata into o_cpu_rdata (reads only; writes leave 0); drop the slave request; o_cpu_ready=1; go to DONE.
  - Otherwise increment the counter. If it reaches TIMEOUT: drop the slave request; o_cpu_rdata=0; o_cpu_ready=1; set error as above; go to DONE.
  - Readies of unselected slaves are ignored.
- DONE:
  - o_cpu_ready is held high while i_cpu_request=1 (4-phase handshake).
  - On the edge where i_cpu_request=0: o_cpu_ready=0, go to IDLE.
  - A new request is accepted no earlier than the edge after return to IDLE.
- Latency: a request sampled at edge N raises the slave request after edge N. A slave that is ready combinationally yields o_cpu_ready after edge N+1. An error decode yields o_cpu_ready after edge N.
- A CPU request drop during ACCESS is a protocol violation. The fabric still completes the slave access and passes through DONE for one cycle.
- Address and wdata changes after latch are ignored until the next IDLE.

Test Plan:
- Read 0x00000200, ROM ready same cycle, rdata 0x12345678 -> o_rom_request high for 1 cycle with o_slave_address=0x200; o_cpu_ready after 2 edges; o_cpu_rdata=0x12345678; o_error=0.
- Write 0x00020010 data 0xCAFEBABE, RAM ready after 3 wait cycles -> o_ram_request high 4 cycles, o_slave_address=0x10, o_slave_wdata=0xCAFEBABE, o_slave_rw=1; then o_cpu_ready.
- Read 0x00030000, the first unmapped address above RAM -> no slave request; o_cpu_ready after 1 edge; rdata 0; o_error=1, o_error_address=0x00030000. A later error leaves o_error_address unchanged.
- Video read 0x10000004 with i_video_ready stuck low -> request drops after TIMEOUT=255 edges; o_cpu_ready=1; rdata 0; o_error set.
- Write to ROM 0x00000100 -> no o_rom_request; error completion. Then back-to-back RAM reads at 0x20000 and 0x20004 -> each waits for request low, second accepted only after IDLE.
- Reset pulse low during ACCESS of a RAM read -> o_ram_request and o_cpu_ready fall immediately. After release, state is IDLE and a fresh read completes normally.
